// File: rtl/uart_cmd_pkg.sv
// Shared types and character constants for the ASCII-hex command decoder.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA_HI,
    DATA_LO,
    TERM
  } state_t;

  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  function automatic logic is_term(input logic [7:0] c);
    return (c == CH_CR) || (c == CH_LF);
  endfunction

  function automatic logic is_cmd(input logic [7:0] c);
    return (c == CH_W) || (c == CH_R);
  endfunction

endpackage

// File: rtl/hex_char_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f to a nibble plus valid flag.
module hex_char_decode (
  input  logic [7:0] i_char,
  output logic [3:0] o_nibble,
  output logic       o_valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_valid  = 1'b1;
    o_nibble = 4'h0;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      o_nibble = i_char[3:0];
    end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                 (i_char >= 8'h61 && i_char <= 8'h66)) begin
      // Letters A-F / a-f have low nibble 1..6; adding 9 gives 10..15.
      o_nibble = i_char[3:0] + 4'h9;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII-hex write/read frame parser driving register strobes from UART RX bytes.
// Optional inter-character timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ClkFrequency = 10000000,
  parameter int unsigned TimeoutUs    = 2000
) (
  input  logic       CLK_10MHZ,
  input  logic       RST_N,
  input  logic       rx_data_ready,
  input  logic [7:0] rx_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_strobe,
  output logic [7:0] rd_addr,
  output logic       err_strobe,
  output logic [7:0] err_count,
  output logic       busy
);

  state_t     r_state, w_next_state;
  logic       r_is_wr, w_next_is_wr;
  logic [7:0] r_addr_sh, w_next_addr_sh;
  logic [7:0] r_data_sh, w_next_data_sh;
  logic       r_wr_strobe, r_rd_strobe, r_err_strobe;
  logic [7:0] r_wr_addr, r_wr_data, r_rd_addr, r_err_count;
  logic       w_fire_wr, w_fire_rd, w_err, w_timeout;
  logic [3:0] w_nibble;
  logic       w_hex_valid;

  hex_char_decode u_hex_char_decode (
    .i_char   (rx_data),
    .o_nibble (w_nibble),
    .o_valid  (w_hex_valid)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TmoCycles = ClkFrequency / 1000000 * TimeoutUs;
  localparam int unsigned TmoW      = (TmoCycles > 1) ? $clog2(TmoCycles) : 1;

  logic [TmoW-1:0] r_tmo_cnt;

  // A byte in the expiry cycle takes priority, so the timeout requires a quiet cycle.
  assign w_timeout = (r_state != IDLE) && !rx_data_ready &&
                     (r_tmo_cnt == TmoW'(TmoCycles - 1));

  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_tmo_cnt <= '0;
    end else if (rx_data_ready || (r_state == IDLE) || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next_state   = r_state;
    w_next_is_wr   = r_is_wr;
    w_next_addr_sh = r_addr_sh;
    w_next_data_sh = r_data_sh;
    w_fire_wr      = 1'b0;
    w_fire_rd      = 1'b0;
    w_err          = 1'b0;
    if (rx_data_ready) begin
      if (is_cmd(rx_data)) begin
        // A command letter always starts a new frame; mid-frame it also flags the lost one.
        w_err        = (r_state != IDLE);
        w_next_state = ADDR_HI;
        w_next_is_wr = (rx_data == CH_W);
      end else begin
        w_next_state = IDLE;
        case (r_state)
          IDLE:    w_err = !(is_term(rx_data) || rx_data == CH_SP);
          ADDR_HI: if (w_hex_valid) begin
                     w_next_addr_sh[7:4] = w_nibble;
                     w_next_state        = ADDR_LO;
                   end else w_err = 1'b1;
          ADDR_LO: if (w_hex_valid) begin
                     w_next_addr_sh[3:0] = w_nibble;
                     w_next_state        = r_is_wr ? DATA_HI : TERM;
                   end else w_err = 1'b1;
          DATA_HI: if (w_hex_valid) begin
                     w_next_data_sh[7:4] = w_nibble;
                     w_next_state        = DATA_LO;
                   end else w_err = 1'b1;
          DATA_LO: if (w_hex_valid) begin
                     w_next_data_sh[3:0] = w_nibble;
                     w_next_state        = TERM;
                   end else w_err = 1'b1;
          TERM:    if (is_term(rx_data)) begin
                     w_fire_wr = r_is_wr;
                     w_fire_rd = !r_is_wr;
                   end else w_err = 1'b1;
          default: w_err = 1'b1;
        endcase
      end
    end else if (w_timeout) begin
      w_err        = 1'b1;
      w_next_state = IDLE;
    end
  end

  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_is_wr      <= 1'b0;
      r_addr_sh    <= 8'h00;
      r_data_sh    <= 8'h00;
      r_wr_strobe  <= 1'b0;
      r_rd_strobe  <= 1'b0;
      r_err_strobe <= 1'b0;
      r_wr_addr    <= 8'h00;
      r_wr_data    <= 8'h00;
      r_rd_addr    <= 8'h00;
      r_err_count  <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_next_state;
      r_is_wr      <= w_next_is_wr;
      r_addr_sh    <= w_next_addr_sh;
      r_data_sh    <= w_next_data_sh;
      r_wr_strobe  <= w_fire_wr;
      r_rd_strobe  <= w_fire_rd;
      r_err_strobe <= w_err;
      // Held outputs only move with their strobe, so partial frames never disturb them.
      if (w_fire_wr) begin
        r_wr_addr <= r_addr_sh;
        r_wr_data <= r_data_sh;
      end
      if (w_fire_rd) r_rd_addr <= r_addr_sh;
      if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign rd_strobe  = r_rd_strobe;
  assign rd_addr    = r_rd_addr;
  assign err_strobe = r_err_strobe;
  assign err_count  = r_err_count;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: frame-level model compared every cycle,
// plus directed literal checks. Honors UART_CMD_TIMEOUT_EN when defined.
module tb_uart_cmd_decoder;

  localparam int unsigned ClkFrequency = 10000000;
  localparam int unsigned TimeoutUs    = 2000;
  localparam int          TmoN         = ClkFrequency / 1000000 * TimeoutUs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_data_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_strobe, rd_strobe, err_strobe, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, err_count;

  uart_cmd_decoder #(
    .ClkFrequency (ClkFrequency),
    .TimeoutUs    (TimeoutUs)
  ) dut (
    .CLK_10MHZ     (clk),
    .RST_N         (rst_n),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_strobe     (rd_strobe),
    .rd_addr       (rd_addr),
    .err_strobe    (err_strobe),
    .err_count     (err_count),
    .busy          (busy)
  );

  always #50 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0, n_rd = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [7:0] m_q[$];
  logic       m_wr = 1'b0, m_rd = 1'b0, m_err = 1'b0;
  logic [7:0] m_wr_addr = 8'h00, m_wr_data = 8'h00, m_rd_addr = 8'h00, m_err_count = 8'h00;
  int         m_gap = 0;

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    if (c >= "a") return int'(c) - 87;
    if (c >= "A") return int'(c) - 55;
    return int'(c) - 48;
  endfunction

  function automatic logic [7:0] hex_byte(input logic [7:0] hi, input logic [7:0] lo);
    return 8'(hex_val(hi) * 16 + hex_val(lo));
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int len;
    if (m_q.size() == 0) begin
      if (b == "W" || b == "R") m_q.push_back(b);
      else if (!(b == 8'h0D || b == 8'h0A || b == 8'h20)) m_err = 1'b1;
    end else if (b == "W" || b == "R") begin
      m_err = 1'b1;
      m_q.delete();
      m_q.push_back(b);
    end else begin
      len = (m_q[0] == "W") ? 5 : 3;
      if (m_q.size() < len && is_hex(b)) begin
        m_q.push_back(b);
      end else if (m_q.size() == len && (b == 8'h0D || b == 8'h0A)) begin
        if (m_q[0] == "W") begin
          m_wr      = 1'b1;
          m_wr_addr = hex_byte(m_q[1], m_q[2]);
          m_wr_data = hex_byte(m_q[3], m_q[4]);
        end else begin
          m_rd      = 1'b1;
          m_rd_addr = hex_byte(m_q[1], m_q[2]);
        end
        m_q.delete();
      end else begin
        m_err = 1'b1;
        m_q.delete();
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_wr = 1'b0; m_rd = 1'b0; m_err = 1'b0;
      m_wr_addr = 8'h00; m_wr_data = 8'h00; m_rd_addr = 8'h00; m_err_count = 8'h00;
      m_gap = 0;
    end else begin
      m_wr = 1'b0; m_rd = 1'b0; m_err = 1'b0;
      if (rx_data_ready) begin
        m_gap = 0;
        model_byte(rx_data);
      end else if (m_q.size() != 0) begin
`ifdef UART_CMD_TIMEOUT_EN
        if (m_gap == TmoN - 1) begin
          m_err = 1'b1;
          m_q.delete();
          m_gap = 0;
        end else begin
          m_gap++;
        end
`endif
      end
      if (m_err && m_err_count != 8'hFF) m_err_count = m_err_count + 8'd1;
    end
  end

  // Compare every cycle on the inactive edge; also tally observed strobes.
  always @(negedge clk) begin
    check("wr_strobe",  32'(wr_strobe),  32'(m_wr));
    check("rd_strobe",  32'(rd_strobe),  32'(m_rd));
    check("err_strobe", 32'(err_strobe), 32'(m_err));
    check("wr_addr",    32'(wr_addr),    32'(m_wr_addr));
    check("wr_data",    32'(wr_data),    32'(m_wr_data));
    check("rd_addr",    32'(rd_addr),    32'(m_rd_addr));
    check("err_count",  32'(err_count),  32'(m_err_count));
    check("busy",       32'(busy),       32'(m_q.size() != 0));
    check("strobe_excl", 32'((int'(wr_strobe) + int'(rd_strobe) + int'(err_strobe)) > 1), 32'd0);
    if (wr_strobe === 1'b1)  n_wr++;
    if (rd_strobe === 1'b1)  n_rd++;
    if (err_strobe === 1'b1) n_err++;
  end

  // ---------------- stimulus ----------------
  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_data_ready = 1'b1;
      rx_data       = s[i];
      if (gap > 0) begin
        @(negedge clk);
        rx_data_ready = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    rx_data_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr",   32'(wr_addr),   32'd0);
    check("rst_rd_addr",   32'(rd_addr),   32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    #10 rst_n = 1'b1;

    // Write frame with gaps, mixed-case hex
    send_str("W3a5F\015", 10);
    settle();
    check("t1_wr_addr", 32'(wr_addr),   32'h3A);
    check("t1_wr_data", 32'(wr_data),   32'h5F);
    check("t1_n_wr",    32'(n_wr),      32'd1);
    check("t1_errcnt",  32'(err_count), 32'd0);

    // Read frame, LF terminator, trailing LF discarded in IDLE
    send_str("R10\n\n", 10);
    settle();
    check("t2_rd_addr", 32'(rd_addr),   32'h10);
    check("t2_n_rd",    32'(n_rd),      32'd1);
    check("t2_n_err",   32'(n_err),     32'd0);

    // Invalid hex mid-frame
    send_str("W1G", 3);
    settle();
    check("t3_errcnt",  32'(err_count), 32'd1);
    check("t3_busy",    32'(busy),      32'd0);
    check("t3_wr_addr", 32'(wr_addr),   32'h3A);
    check("t3_n_err",   32'(n_err),     32'd1);

    // Resync on R mid-frame
    send_str("W1R22\015", 2);
    settle();
    check("t4_errcnt",  32'(err_count), 32'd2);
    check("t4_rd_addr", 32'(rd_addr),   32'h22);
    check("t4_n_rd",    32'(n_rd),      32'd2);

    // Back-to-back bytes, two frames with no gap at all
    send_str("WfF00\nRAb\015", 0);
    settle();
    check("t5_wr_addr", 32'(wr_addr),   32'hFF);
    check("t5_wr_data", 32'(wr_data),   32'h00);
    check("t5_rd_addr", 32'(rd_addr),   32'hAB);
    check("t5_n_wr",    32'(n_wr),      32'd2);
    check("t5_n_rd",    32'(n_rd),      32'd3);

    // Silent whitespace, early terminator, lowercase command letter
    send_str(" \015\nW1\015w", 0);
    settle();
    check("t6_errcnt",  32'(err_count), 32'd4);
    check("t6_busy",    32'(busy),      32'd0);

`ifdef UART_CMD_TIMEOUT_EN
    // Expiry after a quiet gap
    send_str("W1", 0);
    idle(TmoN + 5);
    #1;
    check("t7_busy",    32'(busy),      32'd0);
    check("t7_errcnt",  32'(err_count), 32'd5);
    // Byte lands exactly in the expiry cycle: byte wins
    send_str("W1", 0);
    idle(TmoN - 2);
    send_str("2", 0);
    #1;
    check("t7b_busy",   32'(busy),      32'd1);
    check("t7b_errcnt", 32'(err_count), 32'd5);
    send_str("34\015", 0);
    settle();
    check("t7b_wr_addr", 32'(wr_addr),  32'h12);
    check("t7b_wr_data", 32'(wr_data),  32'h34);
`else
    // Without the timeout a partial frame waits indefinitely
    send_str("W1", 0);
    idle(200);
    #1;
    check("t7_busy",    32'(busy),      32'd1);
    check("t7_errcnt",  32'(err_count), 32'd4);
    send_str("234\015", 0);
    settle();
    check("t7_wr_addr", 32'(wr_addr),   32'h12);
    check("t7_wr_data", 32'(wr_data),   32'h34);
`endif
    check("t7_n_wr",    32'(n_wr),      32'd3);

    // Saturation: 300 x 'A' in IDLE
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rx_data_ready = 1'b1;
      rx_data       = 8'h41;
    end
    @(negedge clk);
    rx_data_ready = 1'b0;
    settle();
    check("t8_errcnt",  32'(err_count), 32'hFF);

    // Reset mid-frame: outputs cleared, no strobe
    send_str("W12", 0);
    #1;
    check("t9_busy_pre", 32'(busy),     32'd1);
    #10 rst_n = 1'b0;
    #1;
    check("t9_wr_addr", 32'(wr_addr),   32'd0);
    check("t9_rd_addr", 32'(rd_addr),   32'd0);
    check("t9_errcnt",  32'(err_count), 32'd0);
    check("t9_busy",    32'(busy),      32'd0);
    idle(3);
    #10 rst_n = 1'b1;
    settle();
    check("t9_n_wr",    32'(n_wr),      32'd3);
    check("t9_n_rd",    32'(n_rd),      32'd3);

    // Recovery after reset
    send_str("R55\015", 1);
    settle();
    check("t10_rd_addr", 32'(rd_addr),  32'h55);
    check("t10_n_rd",    32'(n_rd),     32'd4);
    check("t10_errcnt",  32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
